// File: rtl/alu_rv32i.sv
// rtl/alu_rv32i.sv - RV32I execute-stage ALU with registered EX/MEM copy
//
// Purpose: combinational RV32I ALU (arithmetic, logic, shift, compare, LUI,
// link address, branch condition) plus a one-cycle registered copy of its
// outputs. Optional RV32M multiply/divide is enabled by defining the macro
// ALU_MULDIV_EN; without it codes 32-39 behave as unlisted codes.
//
// Ports:
//   clk          rising-edge clock, drives only the registered outputs
//   rst_n        synchronous active-low reset of the registered outputs
//   alucode      6-bit operation select
//   r1, r2       rs1 / rs2 values
//   imm          sign-extended immediate (already shifted for LUI)
//   pc           PC of the instruction
//   using_r2     1: opB = r2, 0: opB = imm
//   using_pc     1: opA = pc, 0: opA = r1
//   alu_result   combinational result
//   br           combinational branch/jump-taken flag
//   alu_result_q registered alu_result
//   br_q         registered br

module alu_rv32i (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  alucode,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        using_r2,
    input  logic        using_pc,
    output logic [31:0] alu_result,
    output logic        br,
    output logic [31:0] alu_result_q,
    output logic        br_q
);

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_SLT    = 6'd2;
    localparam logic [5:0] OP_SLTU   = 6'd3;
    localparam logic [5:0] OP_XOR    = 6'd4;
    localparam logic [5:0] OP_OR     = 6'd5;
    localparam logic [5:0] OP_AND    = 6'd6;
    localparam logic [5:0] OP_SLL    = 6'd7;
    localparam logic [5:0] OP_SRL    = 6'd8;
    localparam logic [5:0] OP_SRA    = 6'd9;
    localparam logic [5:0] OP_LUI    = 6'd10;
    localparam logic [5:0] OP_JAL    = 6'd11;
    localparam logic [5:0] OP_JALR   = 6'd12;
    localparam logic [5:0] OP_BEQ    = 6'd13;
    localparam logic [5:0] OP_BNE    = 6'd14;
    localparam logic [5:0] OP_BLT    = 6'd15;
    localparam logic [5:0] OP_BGE    = 6'd16;
    localparam logic [5:0] OP_BLTU   = 6'd17;
    localparam logic [5:0] OP_BGEU   = 6'd18;
`ifdef ALU_MULDIV_EN
    localparam logic [5:0] OP_MUL    = 6'd32;
    localparam logic [5:0] OP_MULH   = 6'd33;
    localparam logic [5:0] OP_MULHSU = 6'd34;
    localparam logic [5:0] OP_MULHU  = 6'd35;
    localparam logic [5:0] OP_DIV    = 6'd36;
    localparam logic [5:0] OP_DIVU   = 6'd37;
    localparam logic [5:0] OP_REM    = 6'd38;
    localparam logic [5:0] OP_REMU   = 6'd39;
`endif

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;

    assign op_a  = using_pc ? pc : r1;
    assign op_b  = using_r2 ? r2 : imm;
    assign shamt = op_b[4:0];

`ifdef ALU_MULDIV_EN
    // Operands widened to 64 bits with the signedness each MULH variant needs;
    // a 64x64 product truncated to 64 bits is the exact 32x32 product.
    logic [63:0] a_s64;
    logic [63:0] a_u64;
    logic [63:0] b_s64;
    logic [63:0] b_u64;
    logic [31:0] mul_lo;
    logic [31:0] mulh_ss;
    logic [31:0] mulh_su;
    logic [31:0] mulh_uu;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] divu_q;
    logic [31:0] divu_r;

    assign a_s64   = {{32{op_a[31]}}, op_a};
    assign a_u64   = {32'd0, op_a};
    assign b_s64   = {{32{op_b[31]}}, op_b};
    assign b_u64   = {32'd0, op_b};
    assign mul_lo  = op_a * op_b;
    assign mulh_ss = 32'((a_s64 * b_s64) >> 32);
    assign mulh_su = 32'((a_s64 * b_u64) >> 32);
    assign mulh_uu = 32'((a_u64 * b_u64) >> 32);

    // Divide-by-zero and signed overflow are resolved explicitly so the
    // native operators only ever see well-defined operands.
    always_comb begin
        div_q  = 32'hFFFF_FFFF;
        div_r  = op_a;
        divu_q = 32'hFFFF_FFFF;
        divu_r = op_a;
        if (op_b != 32'd0) begin
            divu_q = op_a / op_b;
            divu_r = op_a % op_b;
            if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                div_q = 32'h8000_0000;
                div_r = 32'd0;
            end else begin
                div_q = $unsigned($signed(op_a) / $signed(op_b));
                div_r = $unsigned($signed(op_a) % $signed(op_b));
            end
        end
    end
`endif

    always_comb begin
        alu_result = 32'd0;
        br         = 1'b0;
        case (alucode)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_result = {31'd0, op_a < op_b};
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_SLL:  alu_result = op_a << shamt;
            OP_SRL:  alu_result = op_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            OP_LUI:  alu_result = imm;
            OP_JAL, OP_JALR: begin
                alu_result = pc + 32'd4;
                br         = 1'b1;
            end
            // Branch conditions compare the raw register values.
            OP_BEQ:  br = (r1 == r2);
            OP_BNE:  br = (r1 != r2);
            OP_BLT:  br = ($signed(r1) < $signed(r2));
            OP_BGE:  br = ($signed(r1) >= $signed(r2));
            OP_BLTU: br = (r1 < r2);
            OP_BGEU: br = (r1 >= r2);
`ifdef ALU_MULDIV_EN
            OP_MUL:    alu_result = mul_lo;
            OP_MULH:   alu_result = mulh_ss;
            OP_MULHSU: alu_result = mulh_su;
            OP_MULHU:  alu_result = mulh_uu;
            OP_DIV:    alu_result = div_q;
            OP_DIVU:   alu_result = divu_q;
            OP_REM:    alu_result = div_r;
            OP_REMU:   alu_result = divu_r;
`endif
            default: begin
                alu_result = 32'd0;
                br         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_result_q <= 32'd0;
            br_q         <= 1'b0;
        end else begin
            alu_result_q <= alu_result;
            br_q         <= br;
        end
    end

endmodule

// File: tb/tb_alu_rv32i.sv
// tb/tb_alu_rv32i.sv - directed self-checking bench for alu_rv32i

module tb_alu_rv32i;

    logic        clk;
    logic        rst_n;
    logic [5:0]  alucode;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        using_r2;
    logic        using_pc;
    logic [31:0] alu_result;
    logic        br;
    logic [31:0] alu_result_q;
    logic        br_q;

    int n_checks;
    int n_pass;

    alu_rv32i dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alucode      (alucode),
        .r1           (r1),
        .r2           (r2),
        .imm          (imm),
        .pc           (pc),
        .using_r2     (using_r2),
        .using_pc     (using_pc),
        .alu_result   (alu_result),
        .br           (br),
        .alu_result_q (alu_result_q),
        .br_q         (br_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Register-register operation, then let the combinational path settle.
    task automatic apply_rr(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        alucode  = code;
        r1       = a;
        r2       = b;
        using_r2 = 1'b1;
        using_pc = 1'b0;
        #1;
    endtask

    task automatic check_rr(input string tag, input logic [5:0] code,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_br);
        apply_rr(code, a, b);
        check({tag, ".res"}, alu_result, exp_res);
        check({tag, ".br"}, {31'd0, br}, {31'd0, exp_br});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        alucode  = 6'd0;
        r1       = 32'd0;
        r2       = 32'd0;
        imm      = 32'd0;
        pc       = 32'd0;
        using_r2 = 1'b1;
        using_pc = 1'b0;

        // Reset: hold a JAL (result pc+4, br=1) so a missing reset is visible.
        @(posedge clk);
        #1;
        alucode = 6'd11;
        pc      = 32'h0000_2000;
        #1;
        check("comb_in_reset.res", alu_result, 32'h0000_2004);
        @(posedge clk);
        #1;
        check("reset.res_q", alu_result_q, 32'd0);
        check("reset.br_q", {31'd0, br_q}, 32'd0);

        // Arithmetic
        check_rr("add",  6'd0, 32'd34, 32'd55, 32'd89, 1'b0);
        check_rr("sub",  6'd1, 32'd55, 32'd56, 32'hFFFF_FFFF, 1'b0);
        check_rr("slt",  6'd2, 32'hFEED_FACE, 32'hBADC_AB1E, 32'd0, 1'b0);
        check_rr("slt1", 6'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        check_rr("sltu", 6'd3, 32'hBADC_AB1E, 32'hFEED_FACE, 32'd1, 1'b0);

        // Logic
        check_rr("xor", 6'd4, 32'hBADC_AB1E, 32'hFEED_FACE, 32'h4431_51D0, 1'b0);
        check_rr("or",  6'd5, 32'hBADC_AB1E, 32'hFEED_FACE, 32'hFEFD_FBDE, 1'b0);
        check_rr("and", 6'd6, 32'hBADC_AB1E, 32'hFEED_FACE, 32'hBACC_AA0E, 1'b0);

        // Shifts (upper shift-amount bits ignored)
        check_rr("sll", 6'd7, 32'hFEED_FACE, 32'd1036, 32'hDFAC_E000, 1'b0);
        check_rr("srl", 6'd8, 32'hDEAD_DEAD, 32'd16, 32'h0000_DEAD, 1'b0);
        check_rr("sra", 6'd9, 32'hDEAD_DEAD, 32'd16, 32'hFFFF_DEAD, 1'b0);
        check_rr("sra31", 6'd9, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);

        // Operand select: pc + imm
        alucode  = 6'd0;
        using_pc = 1'b1;
        using_r2 = 1'b0;
        pc       = 32'h0000_1000;
        imm      = 32'h0000_0020;
        r1       = 32'h5555_0000;
        r2       = 32'h0000_0777;
        #1;
        check("add_pc_imm", alu_result, 32'h0000_1020);

        // LUI ignores the selects
        alucode = 6'd10;
        imm     = 32'h1234_5000;
        #1;
        check("lui", alu_result, 32'h1234_5000);

        // JAL / JALR
        alucode = 6'd11;
        pc      = 32'h0000_1000;
        #1;
        check("jal.res", alu_result, 32'h0000_1004);
        check("jal.br", {31'd0, br}, 32'd1);
        alucode = 6'd12;
        #1;
        check("jalr.res", alu_result, 32'h0000_1004);
        check("jalr.br", {31'd0, br}, 32'd1);

        // Branches compare r1/r2 even with using_r2=0
        using_r2 = 1'b0;
        using_pc = 1'b1;
        imm      = 32'hFFFF_FFFF;
        r1       = 32'hFFFF_FFFF;
        r2       = 32'd1;
        alucode  = 6'd15;
        #1;
        check("blt_sel.br", {31'd0, br}, 32'd1);
        check("blt_sel.res", alu_result, 32'd0);
        check_rr("blt",  6'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check_rr("bltu", 6'd17, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        check_rr("bge",  6'd16, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        check_rr("bgeu", 6'd18, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check_rr("bne",  6'd14, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        check_rr("beq",  6'd13, 32'd5, 32'd5, 32'd0, 1'b1);
        check_rr("beq0", 6'd13, 32'd5, 32'd6, 32'd0, 1'b0);

        // Unlisted code
        check_rr("unlisted19", 6'd19, 32'd7, 32'd9, 32'd0, 1'b0);
        check_rr("unlisted63", 6'd63, 32'd7, 32'd9, 32'd0, 1'b0);

`ifdef ALU_MULDIV_EN
        check_rr("div0",    6'd36, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);
        check_rr("rem0",    6'd38, 32'd7, 32'd0, 32'd7, 1'b0);
        check_rr("mulhu",   6'd35, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        check_rr("mulh",    6'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check_rr("mulhsu",  6'd34, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_rr("mul",     6'd32, 32'd3, 32'd4, 32'd12, 1'b0);
        check_rr("div_ovf", 6'd36, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        check_rr("rem_ovf", 6'd38, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check_rr("div_neg", 6'd36, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        check_rr("rem_neg", 6'd38, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        check_rr("divu",    6'd37, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
        check_rr("remu",    6'd39, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0);
`else
        check_rr("mul_off",  6'd32, 32'd3, 32'd4, 32'd0, 1'b0);
        check_rr("div_off",  6'd36, 32'd7, 32'd0, 32'd0, 1'b0);
        check_rr("remu_off", 6'd39, 32'd7, 32'd2, 32'd0, 1'b0);
`endif

        // Registered path after reset release
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_rr(6'd0, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        check("reg_add.res_q", alu_result_q, 32'd3);
        check("reg_add.br_q", {31'd0, br_q}, 32'd0);

        // Back-to-back: JAL then BEQ not-taken
        alucode = 6'd11;
        pc      = 32'h0000_0100;
        @(posedge clk);
        #1;
        check("reg_jal.res_q", alu_result_q, 32'h0000_0104);
        check("reg_jal.br_q", {31'd0, br_q}, 32'd1);
        apply_rr(6'd13, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        check("reg_beq.res_q", alu_result_q, 32'd0);
        check("reg_beq.br_q", {31'd0, br_q}, 32'd0);

        // Reset overrides load
        apply_rr(6'd0, 32'd10, 32'd20);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset2.res_q", alu_result_q, 32'd0);
        check("comb_in_reset2", alu_result, 32'd30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
